// File: rtl/sc_reglane_bank.sv
// rtl/sc_reglane_bank.sv - bank of independently rotating lane pattern registers for the Frogger datapath
module sc_reglane_bank #(
    parameter int RegLANE_DATAWIDTH   = 8,
    parameter int RegLANE_LANES       = 4,
    parameter int RegLANE_SELWIDTH    = 2,
    parameter int RegLANE_PERIODWIDTH = 8,
    parameter logic [RegLANE_DATAWIDTH-1:0] DATA_FIXED_INITLANE = 8'b00000000
) (
    input  logic                                         SC_RegPOINTTYPE_CLOCK_50,
    input  logic                                         SC_RegPOINTTYPE_RESET_InHigh,
    input  logic                                         SC_RegLANE_clear_InLow,
    input  logic                                         SC_RegLANE_enable_In,
    input  logic                                         SC_RegLANE_load_InLow,
    input  logic [RegLANE_SELWIDTH-1:0]                  SC_RegLANE_loadsel_In,
    input  logic [RegLANE_DATAWIDTH-1:0]                 SC_RegLANE_data_InBUS,
    input  logic                                         SC_RegLANE_cfg_InLow,
    input  logic [RegLANE_SELWIDTH-1:0]                  SC_RegLANE_cfgsel_In,
    input  logic [RegLANE_PERIODWIDTH-1:0]               SC_RegLANE_period_In,
    input  logic                                         SC_RegLANE_dir_In,
    output logic [RegLANE_LANES*RegLANE_DATAWIDTH-1:0]   SC_RegLANE_data_OutBUS,
    output logic [RegLANE_LANES-1:0]                     SC_RegLANE_step_Out
);

    localparam int DW = RegLANE_DATAWIDTH;
    localparam int PW = RegLANE_PERIODWIDTH;
    localparam int SW = RegLANE_SELWIDTH;

    logic clearActive;
    logic loadActive;
    logic cfgActive;

    assign clearActive = ~SC_RegLANE_clear_InLow;
    assign loadActive  = ~SC_RegLANE_load_InLow;
    assign cfgActive   = ~SC_RegLANE_cfg_InLow;

    for (genvar i = 0; i < RegLANE_LANES; i++) begin : laneGen
        localparam logic [SW-1:0] LANE_IDX = SW'(i);

        logic [DW-1:0] patternReg;
        logic [PW-1:0] periodReg;
        logic [PW-1:0] countReg;
        logic          dirReg;
        logic          stepReg;

        logic          loadHit;
        logic          cfgHit;
        logic          running;
        logic          rotateNow;
        logic [DW-1:0] rotated;

        // Selectors beyond the last lane simply match no lane.
        assign loadHit   = loadActive && (SC_RegLANE_loadsel_In == LANE_IDX);
        assign cfgHit    = cfgActive && (SC_RegLANE_cfgsel_In == LANE_IDX);
        assign running   = SC_RegLANE_enable_In && (periodReg != '0);
        assign rotateNow = running && (countReg == periodReg - PW'(1));
        assign rotated   = dirReg ? {patternReg[0], patternReg[DW-1:1]}
                                  : {patternReg[DW-2:0], patternReg[DW-1]};

        always_ff @(posedge SC_RegPOINTTYPE_CLOCK_50 or posedge SC_RegPOINTTYPE_RESET_InHigh) begin
            if (SC_RegPOINTTYPE_RESET_InHigh) begin
                patternReg <= '0;
                periodReg  <= '0;
                countReg   <= '0;
                dirReg     <= 1'b0;
                stepReg    <= 1'b0;
            end else begin
                stepReg <= 1'b0;
                if (clearActive) begin
                    patternReg <= DATA_FIXED_INITLANE;
                    countReg   <= '0;
                end else if (loadHit) begin
                    patternReg <= SC_RegLANE_data_InBUS;
                    countReg   <= '0;
                end else if (rotateNow) begin
                    patternReg <= rotated;
                    countReg   <= '0;
                    stepReg    <= 1'b1;
                end else if (running) begin
                    countReg <= countReg + PW'(1);
                end
                // Config restarts the count regardless of what the pattern path did.
                if (cfgHit) begin
                    periodReg <= SC_RegLANE_period_In;
                    dirReg    <= SC_RegLANE_dir_In;
                    countReg  <= '0;
                end
            end
        end

        assign SC_RegLANE_data_OutBUS[i*DW +: DW] = patternReg;
        assign SC_RegLANE_step_Out[i]             = stepReg;
    end

endmodule

// File: tb/tb_sc_reglane_bank.sv
// tb/tb_sc_reglane_bank.sv - scoreboard bench for sc_reglane_bank
module tb_sc_reglane_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clearN = 1'b1;
    logic        enable = 1'b1;
    logic        loadN = 1'b1;
    logic [2:0]  loadSel = '0;
    logic [7:0]  dataIn = '0;
    logic        cfgN = 1'b1;
    logic [2:0]  cfgSel = '0;
    logic [7:0]  period = '0;
    logic        dir = 1'b0;
    logic [31:0] dataOut;
    logic [3:0]  stepOut;

    int checks = 0;
    int errors = 0;
    logic [35:0] expQ[$];
    logic [35:0] expEntry;

    sc_reglane_bank #(
        .RegLANE_DATAWIDTH(8),
        .RegLANE_LANES(4),
        .RegLANE_SELWIDTH(3),
        .RegLANE_PERIODWIDTH(8),
        .DATA_FIXED_INITLANE(8'hF0)
    ) dut (
        .SC_RegPOINTTYPE_CLOCK_50(clk),
        .SC_RegPOINTTYPE_RESET_InHigh(rst),
        .SC_RegLANE_clear_InLow(clearN),
        .SC_RegLANE_enable_In(enable),
        .SC_RegLANE_load_InLow(loadN),
        .SC_RegLANE_loadsel_In(loadSel),
        .SC_RegLANE_data_InBUS(dataIn),
        .SC_RegLANE_cfg_InLow(cfgN),
        .SC_RegLANE_cfgsel_In(cfgSel),
        .SC_RegLANE_period_In(period),
        .SC_RegLANE_dir_In(dir),
        .SC_RegLANE_data_OutBUS(dataOut),
        .SC_RegLANE_step_Out(stepOut)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clearN = 1'b1;
        loadN  = 1'b1;
        cfgN   = 1'b1;
        enable = 1'b1;
    endtask

    task automatic doCfg(input logic [2:0] sel, input logic [7:0] p, input logic d);
        cfgN   = 1'b0;
        cfgSel = sel;
        period = p;
        dir    = d;
    endtask

    task automatic doLoad(input logic [2:0] sel, input logic [7:0] d);
        loadN   = 1'b0;
        loadSel = sel;
        dataIn  = d;
    endtask

    task automatic expect_step(input logic [3:0] s, input logic [31:0] d);
        expQ.push_back({s, d});
    endtask

    // Every rotation event must match the next scoreboard entry.
    always @(negedge clk) begin
        if (!rst && stepOut != 4'b0) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_step actual step=%b data=%h expected no step", stepOut, dataOut);
            end else begin
                expEntry = expQ.pop_front();
                chk("step_pulse", {28'b0, stepOut}, {28'b0, expEntry[35:32]});
                chk("step_data", dataOut, expEntry[31:0]);
            end
        end
    end

    initial begin
        logic [7:0] seq2 [8] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
        logic [7:0] seq3 [8] = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80};

        #2;
        chk("reset_data", dataOut, 32'h0);
        chk("reset_step", {28'b0, stepOut}, 32'h0);
        tick();
        tick();
        rst = 1'b0;

        for (int k = 0; k < 20; k++) begin
            tick();
            chk("idle_data", dataOut, 32'h0);
            chk("idle_step", {28'b0, stepOut}, 32'h0);
        end

        for (int k = 0; k < 8; k++) expect_step(4'b0001, {24'h0, seq2[k]});
        doLoad(3'd0, 8'h01);
        doCfg(3'd0, 8'd3, 1'b0);
        tick();
        idle();
        chk("lane0_load", dataOut, 32'h0000_0001);
        repeat (24) tick();
        chk("lane0_after24", dataOut, 32'h0000_0001);
        doCfg(3'd0, 8'd0, 1'b0);
        tick();
        idle();

        for (int k = 0; k < 8; k++) expect_step(4'b0010, {16'h0, seq3[k], 8'h01});
        doLoad(3'd1, 8'h80);
        doCfg(3'd1, 8'd1, 1'b1);
        tick();
        idle();
        chk("lane1_load", dataOut, 32'h0000_8001);
        repeat (8) tick();
        enable = 1'b0;
        doCfg(3'd1, 8'd0, 1'b0);
        tick();
        idle();
        chk("lane1_paused", dataOut, 32'h0000_8001);

        expect_step(4'b0001, 32'h0000_8002);
        expect_step(4'b0001, 32'hF0F0_F0E1);
        expect_step(4'b0010, 32'hF0F0_78E1);
        doCfg(3'd0, 8'd2, 1'b0);
        tick();
        doCfg(3'd1, 8'd3, 1'b1);
        tick();
        idle();
        tick();
        tick();
        clearN = 1'b0;
        tick();
        idle();
        chk("clear_data", dataOut, 32'hF0F0_F0F0);
        chk("clear_step", {28'b0, stepOut}, 32'h0);
        repeat (3) tick();
        enable = 1'b0;
        doCfg(3'd0, 8'd0, 1'b0);
        tick();
        doCfg(3'd1, 8'd0, 1'b0);
        tick();
        idle();
        chk("clear_resumed", dataOut, 32'hF0F0_78E1);

        expect_step(4'b0100, 32'hF01E_78E1);
        doLoad(3'd2, 8'h0F);
        doCfg(3'd2, 8'd2, 1'b0);
        tick();
        doLoad(3'd7, 8'hAA);
        doCfg(3'd7, 8'd1, 1'b0);
        tick();
        idle();
        chk("lane2_load_oob", dataOut, 32'hF00F_78E1);
        tick();
        enable = 1'b0;
        doCfg(3'd2, 8'd0, 1'b0);
        tick();
        idle();
        chk("lane2_paused", dataOut, 32'hF01E_78E1);

        expect_step(4'b0001, 32'hF01E_78C3);
        doCfg(3'd0, 8'd3, 1'b0);
        tick();
        idle();
        tick();
        enable = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("frozen_data", dataOut, 32'hF01E_78E1);
            chk("frozen_step", {28'b0, stepOut}, 32'h0);
        end
        enable = 1'b1;
        tick();
        chk("reenable_first", dataOut, 32'hF01E_78E1);
        tick();
        chk("reenable_rotate", dataOut, 32'hF01E_78C3);

        #5;
        rst = 1'b1;
        #1;
        chk("async_reset_data", dataOut, 32'h0);
        chk("async_reset_step", {28'b0, stepOut}, 32'h0);

        chk("scoreboard_drained", expQ.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
